// File: rtl/generador_frecuencia_var.sv
// rtl/generador_frecuencia_var.sv - variable-frequency square-wave generator
// with debounced up/down buttons, exact-average NCO output and multiplexed decimal readout
module generador_frecuencia_var #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FMIN     = 1,
  parameter int FMAX     = 2000,
  parameter int FINIT    = 1,
  parameter int STEP     = 1,
  parameter int WRAP     = 0,
  parameter int DEB_CYC  = 1_250_000,
  parameter int HOLD_CYC = 25_000_000,
  parameter int REP_CYC  = 5_000_000,
  parameter int NDIG     = 4,
  parameter int SCAN_CYC = 166_667,
  localparam int FW      = $clog2(FMAX + 1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            BOTON_ASC,
  input  logic            BOTON_DES,
  output logic [7:0]      SEG,
  output logic [NDIG-1:0] AN,
  output logic            LED,
  output logic            SALIDA,
  output logic [FW-1:0]   FREQ
);

  localparam int FW1 = FW + 1;
  localparam int DW  = $clog2(DEB_CYC + 1);
  localparam int HW  = $clog2(HOLD_CYC + 1);
  localparam int AW  = $clog2(CLK_HZ + 2 * FMAX);
  localparam int BW  = 4 * NDIG;
  localparam int CW  = $clog2(FW + 1);
  localparam int SW  = $clog2(SCAN_CYC + 1);
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // index 0 = up button, index 1 = down button
  logic [1:0]    btn_raw, sync1, sync2, lvl, lvl_d, pulse;
  logic [DW-1:0] deb_cnt [2];
  logic [HW-1:0] hold_cnt [2];

  assign btn_raw = {BOTON_DES, BOTON_ASC};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          lvl[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
        pulse[i] <= lvl[i] & (~lvl_d[i] | (hold_cnt[i] == HW'(HOLD_CYC - 1)));
        // after the first repeat the counter is rewound so later repeats come every REP_CYC
        if (!lvl[i])
          hold_cnt[i] <= '0;
        else if (hold_cnt[i] == HW'(HOLD_CYC - 1))
          hold_cnt[i] <= HW'(HOLD_CYC - REP_CYC);
        else
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  logic [FW:0] f_up, f_dn;
  assign f_up = {1'b0, FREQ} + FW1'(STEP);
  assign f_dn = {1'b0, FREQ} - FW1'(STEP);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      FREQ <= FW'(FINIT);
    end else if (pulse[0] && !pulse[1]) begin
      if (f_up > FW1'(FMAX))
        FREQ <= (WRAP != 0) ? FW'(FMIN) : FW'(FMAX);
      else
        FREQ <= f_up[FW-1:0];
    end else if (pulse[1] && !pulse[0]) begin
      if (f_dn[FW] || f_dn < FW1'(FMIN))
        FREQ <= (WRAP != 0) ? FW'(FMAX) : FW'(FMIN);
      else
        FREQ <= f_dn[FW-1:0];
    end
  end

  logic [AW-1:0] acc, acc_sum;
  assign acc_sum = acc + AW'({FREQ, 1'b0});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc    <= '0;
      SALIDA <= 1'b0;
    end else if (acc_sum >= AW'(CLK_HZ)) begin
      acc    <= acc_sum - AW'(CLK_HZ);
      SALIDA <= ~SALIDA;
    end else begin
      acc <= acc_sum;
    end
  end

  assign LED = SALIDA;

  logic [1:0]    state;
  logic          pending, shown;
  logic [FW-1:0] last_val, cap;
  logic [BW-1:0] bcd, bcd_adj, digits;
  logic [CW-1:0] bit_cnt;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NDIG; d++)
      if (bcd[4*d +: 4] > 4'd4) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      pending  <= 1'b1;
      shown    <= 1'b0;
      last_val <= '0;
      cap      <= '0;
      bcd      <= '0;
      digits   <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (pending || FREQ != last_val) begin
          cap      <= FREQ;
          last_val <= FREQ;
          pending  <= 1'b0;
          bcd      <= '0;
          bit_cnt  <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          {bcd, cap} <= {bcd_adj, cap} << 1;
          bit_cnt    <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(FW - 1)) state <= S_DONE;
        end
        S_DONE: begin
          digits <= bcd;
          shown  <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'h03;
      4'd1:    seg_of = 8'h9F;
      4'd2:    seg_of = 8'h25;
      4'd3:    seg_of = 8'h0D;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h49;
      4'd6:    seg_of = 8'h41;
      4'd7:    seg_of = 8'h1F;
      4'd8:    seg_of = 8'h01;
      4'd9:    seg_of = 8'h09;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx;
  logic [3:0]    cur_dig;
  assign cur_dig = digits[{dig_idx, 2'b00} +: 4];

  // AN and SEG both derive from the same dig_idx sample, so they always switch together
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt <= '0;
      dig_idx  <= IW'(NDIG - 1);
      AN       <= ~(NDIG'(1) << (NDIG - 1));
      SEG      <= 8'hFF;
    end else begin
      if (scan_cnt == SW'(SCAN_CYC - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == '0) ? IW'(NDIG - 1) : dig_idx - 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      AN  <= ~(NDIG'(1) << dig_idx);
      SEG <= shown ? seg_of(cur_dig) : 8'hFF;
    end
  end

endmodule

// File: tb/tb_generador_frecuencia_var.sv
// tb/tb_generador_frecuencia_var.sv - bench for generador_frecuencia_var (saturating and wrapping instances)
module tb_generador_frecuencia_var;

  localparam int CLK_HZ = 1000, FMIN = 1, FMAX = 20, FINIT = 5, STEP = 1;
  localparam int DEB = 4, HOLD = 50, REP = 10, NDIG = 2, SCAN = 3;
  localparam int FW = $clog2(FMAX + 1);
  localparam int MAXC = 8192;

  logic clk = 1'b0, reset = 1'b1, asc = 1'b0, des = 1'b0;
  logic [7:0] seg0, seg1;
  logic [NDIG-1:0] an0, an1;
  logic led0, led1, sal0, sal1;
  logic [FW-1:0] freq0, freq1;

  int errors = 0, checks = 0;

  generador_frecuencia_var #(.CLK_HZ(CLK_HZ), .FMIN(FMIN), .FMAX(FMAX), .FINIT(FINIT), .STEP(STEP),
    .WRAP(0), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .REP_CYC(REP), .NDIG(NDIG), .SCAN_CYC(SCAN)) u_sat (
    .CLK(clk), .RESET(reset), .BOTON_ASC(asc), .BOTON_DES(des),
    .SEG(seg0), .AN(an0), .LED(led0), .SALIDA(sal0), .FREQ(freq0));

  generador_frecuencia_var #(.CLK_HZ(CLK_HZ), .FMIN(FMIN), .FMAX(FMAX), .FINIT(FINIT), .STEP(STEP),
    .WRAP(1), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .REP_CYC(REP), .NDIG(NDIG), .SCAN_CYC(SCAN)) u_wrap (
    .CLK(clk), .RESET(reset), .BOTON_ASC(asc), .BOTON_DES(des),
    .SEG(seg1), .AN(an1), .LED(led1), .SALIDA(sal1), .FREQ(freq1));

  always #5 clk = ~clk;

  logic [7:0] segtab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  typedef struct {
    string name;
    int    asc_len;
    int    des_len;
    bit    bounce;
    int    exp_sat;
    int    exp_wrap;
  } vec_t;
  vec_t vecs [7];

  // reference model state: raw inputs per edge, accepted levels, run starts, frequencies, phase sums
  bit     ra [MAXC];
  bit     rd [MAXC];
  bit     lv [2][MAXC];
  int     rs [2][MAXC];
  int     mf [2];
  int     stab [2];
  longint ms [2];
  int     mc;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; asc = 1'b0; des = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_disp(input int k, input int val, input string nm);
    logic [7:0] s;
    logic [NDIG-1:0] a;
    int idx, zeros, dig;
    s = (k != 0) ? seg1 : seg0;
    a = (k != 0) ? an1 : an0;
    zeros = 0; idx = 0;
    for (int i = 0; i < NDIG; i++) if (!a[i]) begin zeros++; idx = i; end
    check({nm, "_an_onehot"}, zeros, 1);
    dig = val;
    for (int i = 0; i < idx; i++) dig = dig / 10;
    dig = dig % 10;
    check({nm, "_seg"}, int'(s), int'(segtab[dig]));
  endtask

  function automatic bit raw_at(input int b, input int k);
    if (k <= 0) return 1'b0;
    return (b != 0) ? rd[k] : ra[k];
  endfunction

  task automatic model_init();
    mc = 0;
    for (int b = 0; b < 2; b++) begin
      lv[b][0] = 1'b0; rs[b][0] = 0;
      mf[b] = FINIT; ms[b] = 0; stab[b] = 0;
    end
  endtask

  // Accepted level flips after DEB consecutive synchronised samples disagree with it;
  // a step lands two cycles after the flip to 1 and then at HOLD+1, HOLD+1+REP, ... while held.
  task automatic model_update(input int n);
    bit ev [2];
    bit prev, flip;
    int r, since, nf;
    for (int b = 0; b < 2; b++) begin
      prev = lv[b][n-1];
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) if (raw_at(b, n - 2 - j) == prev) flip = 1'b0;
      lv[b][n] = flip ? !prev : prev;
      rs[b][n] = flip ? n : rs[b][n-1];
      ev[b] = 1'b0;
      if (n >= 2 && lv[b][n-2]) begin
        r = rs[b][n-2];
        since = n - 1 - r - HOLD;
        if (r == n - 2) ev[b] = 1'b1;
        else if (since >= 0 && since % REP == 0) ev[b] = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      ms[k] += 2 * mf[k];
      nf = mf[k];
      if (ev[0] && !ev[1])
        nf = (mf[k] + STEP > FMAX) ? ((k != 0) ? FMIN : FMAX) : mf[k] + STEP;
      else if (ev[1] && !ev[0])
        nf = (mf[k] - STEP < FMIN) ? ((k != 0) ? FMAX : FMIN) : mf[k] - STEP;
      stab[k] = (nf == mf[k]) ? stab[k] + 1 : 0;
      mf[k] = nf;
    end
  endtask

  task automatic apply_and_step(input bit a, input bit d);
    int exp_sal;
    asc = a; des = d;
    mc++;
    ra[mc] = a; rd[mc] = d;
    tick();
    model_update(mc);
    for (int k = 0; k < 2; k++) begin
      exp_sal = int'((ms[k] / CLK_HZ) % 2);
      check($sformatf("rnd_freq%0d_c%0d", k, mc), (k != 0) ? int'(freq1) : int'(freq0), mf[k]);
      check($sformatf("rnd_salida%0d_c%0d", k, mc), (k != 0) ? int'(sal1) : int'(sal0), exp_sal);
      check($sformatf("rnd_led%0d_c%0d", k, mc), (k != 0) ? int'(led1) : int'(led0), exp_sal);
      if (stab[k] >= 2 * FW + 6) check_disp(k, mf[k], $sformatf("rnd_disp%0d_c%0d", k, mc));
    end
  endtask

  initial begin
    int tog0, tog1, len, mode;
    logic p0, p1;
    bit a, d;

    vecs[0] = '{"clean_up",    20,  0, 1'b0,  6,  6};
    vecs[1] = '{"bounce_up",   20,  0, 1'b1,  5,  5};
    vecs[2] = '{"hold_up",     85,  0, 1'b0, 10, 10};
    vecs[3] = '{"clean_down",   0, 20, 1'b0,  4,  4};
    vecs[4] = '{"both",        20, 20, 1'b0,  5,  5};
    vecs[5] = '{"hold_down",    0, 85, 1'b0,  1, 20};
    vecs[6] = '{"hold_to_max",195,  0, 1'b0, 20,  1};

    // reset state, then free-running NCO and first display load
    do_reset();
    check("rst_freq0", int'(freq0), FINIT);
    check("rst_freq1", int'(freq1), FINIT);
    check("rst_salida", int'(sal0), 0);
    check("rst_led", int'(led0), 0);
    check("rst_seg0", int'(seg0), 8'hFF);
    check("rst_seg1", int'(seg1), 8'hFF);
    check("rst_an", int'(an0), 2'b01);
    tog0 = 0; tog1 = 0; p0 = sal0; p1 = sal1;
    for (int t = 1; t <= 1000; t++) begin
      tick();
      if (sal0 != p0) tog0++;
      if (sal1 != p1) tog1++;
      p0 = sal0; p1 = sal1;
      if (t == 7) check("blank_before_done", int'(seg0), 8'hFF);
      if (t == 8) check_disp(0, 5, "first_disp");
    end
    check("nco_toggles0", tog0, 10);
    check("nco_toggles1", tog1, 10);

    // exact press-to-FREQ and FREQ-to-digit latency
    do_reset();
    asc = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 7)  check("lat_before", int'(freq0), 5);
      if (t == 8)  check("lat_at", int'(freq0), 6);
      if (t == 15) check_disp(0, 5, "disp_old");
      if (t == 16) check_disp(0, 6, "disp_new");
    end
    asc = 1'b0;
    repeat (30) tick();
    check("one_step_only", int'(freq0), 6);

    // reset in the middle of a conversion
    do_reset();
    asc = 1'b1;
    repeat (11) tick();
    asc = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midconv_freq", int'(freq0), 5);
    check("midconv_seg", int'(seg0), 8'hFF);
    check("midconv_an", int'(an0), 2'b01);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 7) check("midconv_blank", int'(seg0), 8'hFF);
      if (t == 8) check_disp(0, 5, "midconv_disp");
    end
    repeat (20) tick();
    check("midconv_no_event", int'(freq0), 5);

    // table of button scenarios, each from reset
    foreach (vecs[v]) begin
      do_reset();
      len = (vecs[v].asc_len > vecs[v].des_len) ? vecs[v].asc_len : vecs[v].des_len;
      for (int t = 0; t < len; t++) begin
        asc = (t < vecs[v].asc_len) && (!vecs[v].bounce || (t % 2 == 0));
        des = (t < vecs[v].des_len);
        tick();
      end
      asc = 1'b0; des = 1'b0;
      repeat (60) tick();
      check({vecs[v].name, "_sat"}, int'(freq0), vecs[v].exp_sat);
      check({vecs[v].name, "_wrap"}, int'(freq1), vecs[v].exp_wrap);
      check_disp(0, vecs[v].exp_sat, {vecs[v].name, "_disp_a"});
      repeat (SCAN) tick();
      check_disp(0, vecs[v].exp_sat, {vecs[v].name, "_disp_b"});
      check_disp(1, vecs[v].exp_wrap, {vecs[v].name, "_disp_w"});
    end

    // randomized segments against the reference model
    do_reset();
    model_init();
    for (int s = 0; s < 40; s++) begin
      mode = $urandom_range(0, 5);
      len  = $urandom_range(1, 120);
      for (int t = 0; t < len; t++) begin
        case (mode)
          0: begin a = 1'b0; d = 1'b0; end
          1: begin a = 1'b1; d = 1'b0; end
          2: begin a = 1'b0; d = 1'b1; end
          3: begin a = 1'b1; d = 1'b1; end
          4: begin a = 1'($urandom % 2); d = 1'b0; end
          default: begin a = 1'b1; d = ($urandom % 8 == 0); end
        endcase
        apply_and_step(a, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
